uart_tx_frame: RTL



---
 rtl/uart_tx_frame_if.sv | 22 ++
 rtl/uart_tx_frame.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame_if.sv
// Handshake bundle between the TX FIFO read side and the UART transmitter.
interface uart_tx_frame_if #(
    parameter int DATA_W = 8
);
    logic              iTX_VALID;
    logic [DATA_W-1:0] iTX_DATA;
    logic              oTX_READY;

    // FIFO side offers words and watches ready
    modport master (
        output iTX_VALID,
        output iTX_DATA,
        input  oTX_READY
    );

    // Transmitter side consumes words and drives ready
    modport slave (
        input  iTX_VALID,
        input  iTX_DATA,
        output oTX_READY
    );
endinterface

// File: rtl/uart_tx_frame.sv
// UART transmitter: start bit, DATA_W data bits LSB first, optional parity,
// one or two stop bits. Bit timing comes from an internal clock divider.
// A new word may be accepted in the final cycle of the last stop bit, so
// frames can run back to back with no idle gap.
module uart_tx_frame #(
    parameter int CLK_DIV    = 434,
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic           clk,
    input  logic           reset,
    uart_tx_frame_if.slave tx_if,
    output logic           oTX_DATA,
    output logic           oTX_BUSY,
    output logic           oTX_DONE
);
    localparam int BW = $clog2(CLK_DIV);
    localparam logic [BW-1:0] BAUD_ZERO = BW'(0);
    localparam logic [BW-1:0] BAUD_ONE  = BW'(1);
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_DIV - 1);
    // one cycle before the bit ends; used to register DONE ahead of time
    localparam logic [BW-1:0] BAUD_PRE  = BW'(CLK_DIV - 2);
    localparam logic [3:0]    DATA_LAST = 4'(DATA_W - 1);
    localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = (PARITY_ODD != 0);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t            state_q;
    logic [BW-1:0]     baud_q;
    logic [3:0]        bit_q;
    logic [DATA_W-1:0] shift_q;
    logic              par_q;
    logic              line_q;
    logic              busy_q;
    logic              done_q;

    logic last_stop_s;
    logic end_of_frame_s;
    logic ready_s;
    logic accept_s;

    // Even parity is the XOR of the data bits; odd parity inverts it.
    function automatic logic calc_parity(input logic [DATA_W-1:0] d, input logic odd);
        calc_parity = (^d) ^ odd;
    endfunction

    assign last_stop_s    = (state_q == ST_STOP) && (bit_q == STOP_LAST);
    assign end_of_frame_s = last_stop_s && (baud_q == BAUD_LAST);
    // ready is gated by reset so nothing is accepted while reset is held
    assign ready_s        = reset && ((state_q == ST_IDLE) || end_of_frame_s);
    assign accept_s       = tx_if.iTX_VALID && ready_s;

    assign tx_if.oTX_READY = ready_s;
    assign oTX_DATA        = line_q;
    assign oTX_BUSY        = busy_q;
    assign oTX_DONE        = done_q;

    // Frame FSM: baud divider, bit counting, shifting and registered line/busy/done.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_IDLE;
            baud_q  <= BAUD_ZERO;
            bit_q   <= 4'd0;
            shift_q <= '0;
            par_q   <= 1'b0;
            line_q  <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept_s) begin
                shift_q <= tx_if.iTX_DATA;
                par_q   <= calc_parity(tx_if.iTX_DATA, ODD_SEL);
                state_q <= ST_START;
                baud_q  <= BAUD_ZERO;
                bit_q   <= 4'd0;
                line_q  <= 1'b0;
                busy_q  <= 1'b1;
            end else if (state_q == ST_IDLE) begin
                baud_q <= BAUD_ZERO;
                line_q <= 1'b1;
                busy_q <= 1'b0;
            end else if (baud_q != BAUD_LAST) begin
                baud_q <= baud_q + BAUD_ONE;
                // next cycle is the final cycle of the frame
                done_q <= last_stop_s && (baud_q == BAUD_PRE);
            end else begin
                baud_q <= BAUD_ZERO;
                case (state_q)
                    ST_START: begin
                        state_q <= ST_DATA;
                        bit_q   <= 4'd0;
                        line_q  <= shift_q[0];
                    end
                    ST_DATA: begin
                        if (bit_q == DATA_LAST) begin
                            bit_q <= 4'd0;
                            if (PARITY_EN != 0) begin
                                state_q <= ST_PARITY;
                                line_q  <= par_q;
                            end else begin
                                state_q <= ST_STOP;
                                line_q  <= 1'b1;
                            end
                        end else begin
                            bit_q   <= bit_q + 4'd1;
                            shift_q <= shift_q >> 1;
                            line_q  <= shift_q[1];
                        end
                    end
                    ST_PARITY: begin
                        state_q <= ST_STOP;
                        bit_q   <= 4'd0;
                        line_q  <= 1'b1;
                    end
                    ST_STOP: begin
                        line_q <= 1'b1;
                        if (bit_q == STOP_LAST) begin
                            // end of frame with no new word waiting
                            state_q <= ST_IDLE;
                            bit_q   <= 4'd0;
                            busy_q  <= 1'b0;
                        end else begin
                            bit_q <= bit_q + 4'd1;
                        end
                    end
                    default: begin
                        state_q <= ST_IDLE;
                        bit_q   <= 4'd0;
                        line_q  <= 1'b1;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule
